mmio_uart_bridge: RTL and testbench
===================================

# mmio_uart_bridge

Memory-mapped I/O block sitting directly downstream of the CPU's MEM stage, between the core's load/store path and the on-chip UART. It buffers UART traffic in two FIFOs (TX and RX), exposes status and data registers at the 0x8000_00xx window, and keeps cycle and retired-instruction counters. Load data is returned registered, one cycle after the access, matching the synchronous-read latency of dmem and bios_mem.

## Interface
- FIFO_DEPTH, 8, entries per FIFO; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- addr  in  32  MEM-stage address (ALU result)
- wdata  in  32  store data; only [7:0] used
- rd_en  in  1  load strobe, valid this cycle
- wr_en  in  1  store strobe, valid this cycle
- inst_retire  in  1  one instruction retired this cycle
- rdata  out  32  registered load data
- uart_tx_data  out  8  byte to UART transmitter
- uart_tx_valid  out  1  TX FIFO non-empty
- uart_tx_ready  in  1  transmitter accepts byte
- uart_rx_data  in  8  byte from UART receiver
- uart_rx_valid  in  1  receiver has a byte
- uart_rx_ready  out  1  RX FIFO can accept

## Operation
- Decode: access selected only when addr[31:28]==4'b1000; offset is addr[7:0]. Other addresses: no side effect, rdata loads 0 on rd_en.
- 0x00 read: bit0 = TX FIFO not full, bit1 = RX FIFO not empty, bits[31:2]=0.
- 0x04 read: RX FIFO head zero-extended; pops one entry. Empty: returns 0, no pop.
- 0x08 write: pushes wdata[7:0] into TX FIFO. Full: byte dropped, no state change.
- 0x10 read: cycle counter. 0x14 read: instruction counter.
- 0x18 write: clears both counters (data ignored).
- Unmapped offsets inside the window: read 0, writes ignored.
- rd_en and wr_en in the same cycle: both honoured independently.
- FIFOs: circular buffers, log2(FIFO_DEPTH)+1-bit read/write pointers, wrap at depth; full when pointers differ only in MSB.
- TX side: uart_tx_valid = !tx_empty; uart_tx_data = TX head (combinational); pop when valid && ready.
- RX side: uart_rx_ready = !rx_full && !rst; push when valid && ready.
- Simultaneous push/pop on a full or empty FIFO: both occur when each is individually legal at cycle start; count unchanged when both occur. Full TX + CPU push + UART pop: pop succeeds, push dropped (fullness judged at cycle start).
- Cycle counter: +1 every cycle, 32-bit wrap (0xFFFF_FFFF → 0). Instruction counter: +1 on inst_retire, 32-bit wrap.
- Clear vs increment same cycle: clear wins; counter reads 0 next cycle.

## Timing
- rdata updates on the clock edge after rd_en; holds until next rd_en.
- Status read reflects FIFO state at the rd_en cycle, before that cycle's push/pop.
- RX pop takes effect at the same edge rdata is captured; next status read sees updated count.
- TX push visible on uart_tx_valid one cycle after wr_en.
- RX byte accepted at edge N is readable via 0x04 by rd_en at cycle N+1.
- Reset: rdata=0, both FIFOs empty, uart_tx_valid=0, uart_rx_ready=0 during rst then 1, counters=0. Reset mid-operation discards all buffered bytes; an in-flight load's rdata is 0.

## Configuration
- MMIO_COUNTERS_EN defined: cycle/instruction counters and 0x10/0x14/0x18 present as above.
- Undefined: counters not synthesized; 0x10/0x14 read 0, 0x18 write ignored, inst_retire unused.

## Test plan
- After reset, read 0x8000_0000 → rdata=0x1 next cycle; uart_tx_valid=0, uart_rx_ready=1.
- Store 0x41,0x42 to 0x8000_0008 with uart_tx_ready=0 → uart_tx_valid=1, data=0x41; raise ready one cycle → data=0x42.
- Push 9 bytes to TX with ready=0 (depth 8) → status bit0=0 after 8th, 9th dropped; drain yields exactly 8 bytes in order.
- Drive rx byte 0x5A with valid → read 0x04 returns 0x0000_005A, second read returns 0, status bit1=0.
- Run 100 cycles with inst_retire on alternate cycles, read 0x10/0x14 → values differ by ~50; write 0x18 in cycle of retire → both read 0 immediately after.
- Fill RX FIFO, then assert rst for one cycle mid-stream → status=0x1, 0x04 read returns 0.

Source files
------------

// File: rtl/mmio_uart_bridge.sv
// MMIO bridge between the MEM stage and the UART: TX/RX byte FIFOs and status/data registers.
// Define MMIO_COUNTERS_EN to add the cycle and retired-instruction counters at 0x10/0x14/0x18.
module mmio_uart_bridge #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic        inst_retire,
  output logic [31:0] rdata,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_valid,
  input  logic        uart_tx_ready,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef logic [AW:0] ptr_t;

  localparam ptr_t PTR_ONE = ptr_t'(1);

  logic       sel;
  logic [7:0] off;

  assign sel = (addr[31:28] == 4'b1000);
  assign off = addr[7:0];

  logic hit_stat;
  logic hit_rxd;
  logic hit_txd;
  logic hit_cyc;
  logic hit_ins;
  logic hit_clr;

  assign hit_stat = sel && (off == 8'h00);
  assign hit_rxd  = sel && (off == 8'h04);
  assign hit_txd  = sel && (off == 8'h08);
  assign hit_cyc  = sel && (off == 8'h10);
  assign hit_ins  = sel && (off == 8'h14);
  assign hit_clr  = sel && (off == 8'h18);

  // TX FIFO: CPU stores in, UART transmitter drains
  logic [7:0] tx_mem [FIFO_DEPTH];
  ptr_t       tx_wp;
  ptr_t       tx_rp;
  logic       tx_empty;
  logic       tx_full;
  logic       tx_push;
  logic       tx_pop;

  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[AW-1:0] == tx_rp[AW-1:0])
                 && (tx_wp[AW] != tx_rp[AW]);
  assign tx_push  = wr_en && hit_txd && !tx_full;
  assign tx_pop   = !tx_empty && uart_tx_ready;

  assign uart_tx_valid = !tx_empty;
  assign uart_tx_data  = tx_mem[tx_rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (tx_push) begin
      tx_mem[tx_wp[AW-1:0]] <= wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
    end else begin
      if (tx_push) begin
        tx_wp <= tx_wp + PTR_ONE;
      end
      if (tx_pop) begin
        tx_rp <= tx_rp + PTR_ONE;
      end
    end
  end

  // RX FIFO: UART receiver fills, CPU loads from 0x04 drain
  logic [7:0] rx_mem [FIFO_DEPTH];
  ptr_t       rx_wp;
  ptr_t       rx_rp;
  logic       rx_empty;
  logic       rx_full;
  logic       rx_push;
  logic       rx_pop;
  logic [7:0] rx_head;

  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[AW-1:0] == rx_rp[AW-1:0])
                 && (rx_wp[AW] != rx_rp[AW]);
  assign rx_push  = uart_rx_valid && uart_rx_ready;
  assign rx_pop   = rd_en && hit_rxd && !rx_empty;
  assign rx_head  = rx_mem[rx_rp[AW-1:0]];

  assign uart_rx_ready = !rx_full && !rst;

  always_ff @(posedge clk) begin
    if (rx_push) begin
      rx_mem[rx_wp[AW-1:0]] <= uart_rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
    end else begin
      if (rx_push) begin
        rx_wp <= rx_wp + PTR_ONE;
      end
      if (rx_pop) begin
        rx_rp <= rx_rp + PTR_ONE;
      end
    end
  end

`ifdef MMIO_COUNTERS_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ins_cnt;
  logic        cnt_clr;

  assign cnt_clr = wr_en && hit_clr;

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cyc_cnt <= '0;
      ins_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      ins_cnt <= ins_cnt + {31'd0, inst_retire};
    end
  end

  logic unused_ok;
  assign unused_ok = &{1'b0, wdata[31:8], addr[27:8]};
`else
  logic unused_ok;
  assign unused_ok = &{1'b0, wdata[31:8], addr[27:8],
                       inst_retire, hit_cyc, hit_ins, hit_clr};
`endif

  logic [31:0] rd_val;

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      hit_stat: rd_val = {30'd0, !rx_empty, !tx_full};
      hit_rxd:  rd_val = {24'd0, rx_empty ? 8'd0 : rx_head};
`ifdef MMIO_COUNTERS_EN
      hit_cyc:  rd_val = cyc_cnt;
      hit_ins:  rd_val = ins_cnt;
`endif
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Directed bench for mmio_uart_bridge; a queue-based model is checked every cycle,
// with literal expectations pinning the key scenarios.
module tb_mmio_uart_bridge;

  localparam int DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rd_en;
  logic        wr_en;
  logic        inst_retire;
  logic [31:0] rdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid;
  logic        uart_tx_ready;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;

  mmio_uart_bridge #(.FIFO_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .wdata         (wdata),
    .rd_en         (rd_en),
    .wr_en         (wr_en),
    .inst_retire   (inst_retire),
    .rdata         (rdata),
    .uart_tx_data  (uart_tx_data),
    .uart_tx_valid (uart_tx_valid),
    .uart_tx_ready (uart_tx_ready),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  txq [$];
  logic [7:0]  rxq [$];
  logic [31:0] m_rdata;
  logic [31:0] m_cyc;
  logic [31:0] m_ins;
  logic [7:0]  got [32];
  int          ngot;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic compare();
    chk("tx_valid", 32'(uart_tx_valid), 32'(txq.size() != 0));
    if (txq.size() != 0) begin
      chk("tx_data", 32'(uart_tx_data), 32'(txq[0]));
    end
    chk("rx_ready", 32'(uart_rx_ready),
        32'((rxq.size() < DEPTH) && !rst));
    chk("rdata", rdata, m_rdata);
  endtask

  // One clock: evaluate the register map on pre-edge state, then compare.
  task automatic cyc();
    logic [31:0] rv;
    logic        s;
    logic [7:0]  o;
    logic        txo;
    logic        txp;
    logic        rxp;
    logic        rxo;
    logic        clr;
    logic [7:0]  wb;
    logic [7:0]  rb;
    s   = (addr[31:28] == 4'h8);
    o   = addr[7:0];
    rv  = 32'd0;
    if (s) begin
      if (o == 8'h00) begin
        rv[0] = (txq.size() < DEPTH);
        rv[1] = (rxq.size() > 0);
      end
      if (o == 8'h04 && rxq.size() > 0) rv = {24'd0, rxq[0]};
`ifdef MMIO_COUNTERS_EN
      if (o == 8'h10) rv = m_cyc;
      if (o == 8'h14) rv = m_ins;
`endif
    end
    txo = (txq.size() > 0) && uart_tx_ready;
    txp = wr_en && s && (o == 8'h08) && (txq.size() < DEPTH);
    rxp = uart_rx_valid && (rxq.size() < DEPTH);
    rxo = rd_en && s && (o == 8'h04) && (rxq.size() > 0);
    clr = wr_en && s && (o == 8'h18);
    wb  = wdata[7:0];
    rb  = uart_rx_data;
    @(posedge clk);
    if (rst) begin
      m_rdata = 32'd0;
      txq.delete();
      rxq.delete();
      m_cyc = 32'd0;
      m_ins = 32'd0;
    end else begin
      if (rd_en) m_rdata = rv;
      if (txo) void'(txq.pop_front());
      if (txp) txq.push_back(wb);
      if (rxo) void'(rxq.pop_front());
      if (rxp) rxq.push_back(rb);
      if (clr) begin
        m_cyc = 32'd0;
        m_ins = 32'd0;
      end else begin
        m_cyc = m_cyc + 32'd1;
        m_ins = m_ins + 32'(inst_retire);
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic rd(input logic [31:0] a);
    addr  = a;
    rd_en = 1'b1;
    cyc();
    rd_en = 1'b0;
    addr  = 32'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    addr  = a;
    wdata = {24'd0, d};
    wr_en = 1'b1;
    cyc();
    wr_en = 1'b0;
    addr  = 32'd0;
    wdata = 32'd0;
  endtask

  task automatic drain();
    ngot = 0;
    uart_tx_ready = 1'b1;
    for (int k = 0; k < 20 && uart_tx_valid; k++) begin
      got[ngot] = uart_tx_data;
      ngot++;
      cyc();
    end
    uart_tx_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    addr = 32'd0;
    wdata = 32'd0;
    rd_en = 1'b0;
    wr_en = 1'b0;
    inst_retire = 1'b0;
    uart_tx_ready = 1'b0;
    uart_rx_data = 8'd0;
    uart_rx_valid = 1'b0;

    cyc();
    cyc();
    chk("rst_rx_ready", 32'(uart_rx_ready), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    cyc();

    rd(32'h8000_0000);
    chk("status_reset", rdata, 32'h1);
    chk("tx_valid_reset", 32'(uart_tx_valid), 32'd0);
    chk("rx_ready_reset", 32'(uart_rx_ready), 32'd1);

    rd(32'h0000_0000);
    chk("outside_read", rdata, 32'd0);
    wr(32'h4000_0008, 8'h77);
    chk("outside_write", 32'(uart_tx_valid), 32'd0);
    rd(32'h8000_000C);
    chk("unmapped_read", rdata, 32'd0);

    wr(32'h8000_0008, 8'h41);
    wr(32'h8000_0008, 8'h42);
    chk("tx_first_valid", 32'(uart_tx_valid), 32'd1);
    chk("tx_first_data", 32'(uart_tx_data), 32'h41);
    uart_tx_ready = 1'b1;
    cyc();
    uart_tx_ready = 1'b0;
    chk("tx_second_data", 32'(uart_tx_data), 32'h42);
    uart_tx_ready = 1'b1;
    cyc();
    uart_tx_ready = 1'b0;
    chk("tx_drained", 32'(uart_tx_valid), 32'd0);

    for (int i = 0; i < 8; i++) wr(32'h8000_0008, 8'(8'h10 + i));
    rd(32'h8000_0000);
    chk("status_tx_full", rdata, 32'h0);
    wr(32'h8000_0008, 8'h18);
    rd(32'h8000_0000);
    chk("status_still_full", rdata, 32'h0);
    drain();
    chk("drain_count", 32'(ngot), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk("drain_byte", 32'(got[i]), 32'(8'h10 + i));
    end

    for (int i = 0; i < 8; i++) wr(32'h8000_0008, 8'(8'h20 + i));
    uart_tx_ready = 1'b1;
    wr(32'h8000_0008, 8'h99);
    uart_tx_ready = 1'b0;
    rd(32'h8000_0000);
    chk("full_push_pop", rdata, 32'h1);
    drain();
    chk("drain7_count", 32'(ngot), 32'd7);
    chk("drain7_last", 32'(got[6]), 32'h27);

    uart_rx_data = 8'h5A;
    uart_rx_valid = 1'b1;
    cyc();
    uart_rx_valid = 1'b0;
    rd(32'h8000_0004);
    chk("rx_read", rdata, 32'h0000_005A);
    rd(32'h8000_0004);
    chk("rx_read_empty", rdata, 32'h0);
    rd(32'h8000_0000);
    chk("status_rx_empty", rdata, 32'h1);

    wr(32'h8000_0018, 8'h00);
    for (int i = 0; i < 100; i++) begin
      inst_retire = (i % 2 == 0);
      cyc();
    end
    inst_retire = 1'b0;
    rd(32'h8000_0010);
`ifdef MMIO_COUNTERS_EN
    chk("cycle_cnt", rdata, 32'd100);
`else
    chk("cycle_cnt_off", rdata, 32'd0);
`endif
    rd(32'h8000_0014);
`ifdef MMIO_COUNTERS_EN
    chk("inst_cnt", rdata, 32'd50);
`else
    chk("inst_cnt_off", rdata, 32'd0);
`endif
    inst_retire = 1'b1;
    wr(32'h8000_0018, 8'hFF);
    inst_retire = 1'b0;
    rd(32'h8000_0010);
    chk("cycle_clr", rdata, 32'd0);
    rd(32'h8000_0014);
    chk("inst_clr", rdata, 32'd0);

    uart_rx_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      uart_rx_data = 8'(8'h60 + i);
      cyc();
    end
    uart_rx_valid = 1'b0;
    chk("rx_full_ready", 32'(uart_rx_ready), 32'd0);
    rd(32'h8000_0000);
    chk("status_rx_full", rdata, 32'h3);
    addr = 32'h8000_0004;
    rd_en = 1'b1;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    rd_en = 1'b0;
    chk("rst_inflight", rdata, 32'h0);
    cyc();
    chk("rx_ready_after_rst", 32'(uart_rx_ready), 32'd1);
    rd(32'h8000_0000);
    chk("status_after_rst", rdata, 32'h1);
    rd(32'h8000_0004);
    chk("rx_after_rst", rdata, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
